bmu_issue_arbiter: RTL and testbench

- Shares the single-issue BMU datapath between NUM_REQ requesters (e.g. two decode/issue slots).
- Per-cycle round-robin arbitration; drives the BMU operand/control inputs for the winner.
- Tracks in-flight operations through the BMU's fixed result latency and returns each result with requester id and tag.
- Results go through a small response FIFO with valid/ready back-pressure.
- Sits between the issue stage and the BMU.

---
 rtl/bmu_issue_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_bmu_issue_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmu_issue_arbiter.sv
// bmu_issue_arbiter: round-robin share of the single-issue BMU between NUM_REQ
// requesters. It tracks each op through the fixed BMU latency and returns
// {id, tag, result, error} through a small response FIFO with valid/ready.
//
// Ports:
//   clk, rst_l          clock, asynchronous active-low reset
//   flush               synchronous kill of in-flight and queued results
//   req_valid/ready     per-requester handshake (ready = one-hot grant)
//   req_a/b/ap/tag      packed per-requester operands, control and tag
//   bmu_valid_in/a_in/b_in/ap   issue to BMU (same cycle as grant)
//   bmu_result_ff/error result from BMU, BMU_LAT cycles after issue
//   rsp_valid/ready     response handshake
//   rsp_id/tag/result/error     head of the response FIFO (registered)
module bmu_issue_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned AP_W      = 21,
  parameter int unsigned BMU_LAT   = 1,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*32-1:0]         req_a,
  input  logic [NUM_REQ*32-1:0]         req_b,
  input  logic [NUM_REQ*AP_W-1:0]       req_ap,
  input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
  output logic                          bmu_valid_in,
  output logic [31:0]                   bmu_a_in,
  output logic [31:0]                   bmu_b_in,
  output logic [AP_W-1:0]               bmu_ap,
  input  logic [31:0]                   bmu_result_ff,
  input  logic                          bmu_error,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic [31:0]                   rsp_result,
  output logic                          rsp_error
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic             vld;
    logic [ID_W-1:0]  id;
    logic [TAG_W-1:0] tag;
  } pipe_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [TAG_W-1:0] tag;
    logic [31:0]      result;
    logic             error;
  } rsp_t;

  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  pipe_t                pipe_q [BMU_LAT];
  pipe_t                pipe_d [BMU_LAT];
  rsp_t                 fifo_q [RSP_DEPTH];
  rsp_t                 fifo_d [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] fvld_q, fvld_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, infl_cnt, wr_idx;
  logic                 found, grant, out_en, issue_ok, pop, push;
  logic [ID_W-1:0]      win;
  logic [TAG_W-1:0]     win_tag;

  // Credit check: FIFO slots must cover everything already queued or in flight.
  always_comb begin
    infl_cnt = '0;
    for (int unsigned s = 0; s < BMU_LAT; s++) begin
      infl_cnt = infl_cnt + CNT_W'(pipe_q[s].vld);
    end
    pop      = fvld_q[0] & rsp_ready;
    issue_ok = (32'(cnt_q) - 32'(pop) + 32'(infl_cnt)) < RSP_DEPTH;
  end

  // Round-robin search starting at rr_ptr_q, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && req_valid[j] && ((32'(rr_ptr_q) + i) % NUM_REQ) == j) begin
          found = 1'b1;
          win   = ID_W'(j);
        end
      end
    end
    grant = found & issue_ok & ~flush;
    // Reset forces the handshake outputs low without waiting for a clock.
    out_en = grant & rst_l;
  end

  // Winner operand mux to the BMU and one-hot ready.
  always_comb begin
    req_ready    = '0;
    bmu_valid_in = out_en;
    bmu_a_in     = '0;
    bmu_b_in     = '0;
    bmu_ap       = '0;
    win_tag      = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (win == ID_W'(j)) begin
        win_tag = req_tag[j*TAG_W +: TAG_W];
        if (out_en) begin
          req_ready[j] = 1'b1;
          bmu_a_in     = req_a[j*32 +: 32];
          bmu_b_in     = req_b[j*32 +: 32];
          bmu_ap       = req_ap[j*AP_W +: AP_W];
        end
      end
    end
  end

  // Pointer advance and in-flight shift pipe.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = ((32'(win) + 1) == NUM_REQ) ? '0 : win + ID_W'(1);
    end
    pipe_d[0] = '{vld: grant, id: win, tag: win_tag};
    for (int unsigned s = 1; s < BMU_LAT; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end
    if (flush) begin
      for (int unsigned s = 0; s < BMU_LAT; s++) begin
        pipe_d[s].vld = 1'b0;
      end
    end
    push = pipe_q[BMU_LAT-1].vld & ~flush;
  end

  // Shift-style response FIFO: entry 0 is always the head, so rsp_* come straight from flops.
  always_comb begin
    fifo_d = fifo_q;
    fvld_d = fvld_q;
    wr_idx = cnt_q - CNT_W'(pop);
    if (pop) begin
      for (int unsigned k = 0; k < RSP_DEPTH - 1; k++) begin
        fifo_d[k] = fifo_q[k+1];
      end
      fifo_d[RSP_DEPTH-1] = '0;
      fvld_d = fvld_q >> 1;
    end
    if (push) begin
      for (int unsigned k = 0; k < RSP_DEPTH; k++) begin
        if (wr_idx == CNT_W'(k)) begin
          fifo_d[k] = '{id: pipe_q[BMU_LAT-1].id, tag: pipe_q[BMU_LAT-1].tag,
                        result: bmu_result_ff, error: bmu_error};
          fvld_d[k] = 1'b1;
        end
      end
    end
    cnt_d = cnt_q - CNT_W'(pop) + CNT_W'(push);
    if (flush) begin
      for (int unsigned k = 0; k < RSP_DEPTH; k++) begin
        fifo_d[k] = '0;
      end
      fvld_d = '0;
      cnt_d  = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rr_ptr_q <= '0;
      for (int unsigned s = 0; s < BMU_LAT; s++) begin
        pipe_q[s] <= '0;
      end
      for (int unsigned k = 0; k < RSP_DEPTH; k++) begin
        fifo_q[k] <= '0;
      end
      fvld_q <= '0;
      cnt_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      pipe_q   <= pipe_d;
      fifo_q   <= fifo_d;
      fvld_q   <= fvld_d;
      cnt_q    <= cnt_d;
    end
  end

  // The credit rule makes overflow unreachable.
  always_ff @(posedge clk) begin
    if (rst_l && push && !pop) begin
      assert (cnt_q != CNT_W'(RSP_DEPTH));
    end
  end

  assign rsp_valid  = fvld_q[0];
  assign rsp_id     = fifo_q[0].id;
  assign rsp_tag    = fifo_q[0].tag;
  assign rsp_result = fifo_q[0].result;
  assign rsp_error  = fifo_q[0].error;

endmodule

// File: tb/tb_bmu_issue_arbiter.sv
// Directed bench for bmu_issue_arbiter (NUM_REQ=2, BMU_LAT=1, RSP_DEPTH=2).
// A tiny BMU model adds a+b one cycle after issue and raises error for AP_ERR.
module tb_bmu_issue_arbiter;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned AP_W      = 21;
  localparam int unsigned BMU_LAT   = 1;
  localparam int unsigned RSP_DEPTH = 2;
  localparam logic [AP_W-1:0] AP_ADD = 21'h1;
  localparam logic [AP_W-1:0] AP_ERR = 21'h2;

  logic                     clk;
  logic                     rst_l;
  logic                     flush;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*32-1:0]    req_a;
  logic [NUM_REQ*32-1:0]    req_b;
  logic [NUM_REQ*AP_W-1:0]  req_ap;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic                     bmu_valid_in;
  logic [31:0]              bmu_a_in;
  logic [31:0]              bmu_b_in;
  logic [AP_W-1:0]          bmu_ap;
  logic [31:0]              bmu_result_ff;
  logic                     bmu_error;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [0:0]               rsp_id;
  logic [TAG_W-1:0]         rsp_tag;
  logic [31:0]              rsp_result;
  logic                     rsp_error;

  int n_vec = 0;
  int n_err = 0;

  bmu_issue_arbiter #(
    .NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .AP_W(AP_W),
    .BMU_LAT(BMU_LAT), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .rst_l(rst_l), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ap(req_ap), .req_tag(req_tag),
    .bmu_valid_in(bmu_valid_in), .bmu_a_in(bmu_a_in), .bmu_b_in(bmu_b_in),
    .bmu_ap(bmu_ap), .bmu_result_ff(bmu_result_ff), .bmu_error(bmu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_error(rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle BMU stand-in.
  always @(posedge clk) begin
    if (bmu_valid_in) begin
      bmu_result_ff <= bmu_a_in + bmu_b_in;
      bmu_error     <= (bmu_ap == AP_ERR);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_rsp(input string name, input logic [0:0] id, input logic [TAG_W-1:0] tag,
                         input logic [31:0] result, input logic err);
    check({name, "_valid"},  64'(rsp_valid),  64'(1));
    check({name, "_id"},     64'(rsp_id),     64'(id));
    check({name, "_tag"},    64'(rsp_tag),    64'(tag));
    check({name, "_result"}, 64'(rsp_result), 64'(result));
    check({name, "_error"},  64'(rsp_error),  64'(err));
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [AP_W-1:0] ap, input logic [TAG_W-1:0] tag);
    req_a[r*32 +: 32]       = a;
    req_b[r*32 +: 32]       = b;
    req_ap[r*AP_W +: AP_W]  = ap;
    req_tag[r*TAG_W +: TAG_W] = tag;
  endtask

  initial begin
    rst_l     = 1'b0;
    flush     = 1'b0;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_ap    = '0;
    req_tag   = '0;
    rsp_ready = 1'b0;

    // Reset state, with requests pending that must not be granted.
    #2;
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_bmu_valid", 64'(bmu_valid_in), 64'(0));
    check("rst_rsp_tag",   64'(rsp_tag), 64'(0));
    req_valid = 2'b00;
    #10 rst_l = 1'b1;
    tick();

    // Single request from requester 0.
    set_req(0, 32'h0000_000F, 32'h0000_0001, AP_ADD, 4'd3);
    req_valid = 2'b01;
    settle();
    check("single_ready", 64'(req_ready), 64'(1));
    check("single_bmu_valid", 64'(bmu_valid_in), 64'(1));
    check("single_bmu_a", 64'(bmu_a_in), 64'h0F);
    check("single_bmu_b", 64'(bmu_b_in), 64'h01);
    check("single_bmu_ap", 64'(bmu_ap), 64'(AP_ADD));
    tick();
    req_valid = 2'b00;
    settle();
    check("single_lat1_empty", 64'(rsp_valid), 64'(0));
    check("idle_bmu_a_zero", 64'(bmu_a_in), 64'(0));
    tick();
    settle();
    chk_rsp("single_rsp", 1'b0, 4'd3, 32'h10, 1'b0);
    rsp_ready = 1'b1;
    tick();
    settle();
    check("single_drained", 64'(rsp_valid), 64'(0));

    // Requester 1 alone; pointer was at 1 and returns to 0 afterwards.
    set_req(1, 32'h100, 32'h23, AP_ADD, 4'd5);
    req_valid = 2'b10;
    settle();
    check("solo1_ready", 64'(req_ready), 64'(2));
    tick();
    req_valid = 2'b00;
    tick();
    settle();
    chk_rsp("solo1_rsp", 1'b1, 4'd5, 32'h123, 1'b0);
    tick();
    settle();
    check("solo1_drained", 64'(rsp_valid), 64'(0));

    // Contention: six cycles of both valid, one issue per cycle, alternating.
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        set_req(0, 32'(k), 32'd100, AP_ADD, 4'(k));
        set_req(1, 32'(k), 32'd200, AP_ADD, 4'(8 + k));
        req_valid = 2'b11;
      end else begin
        req_valid = 2'b00;
      end
      settle();
      if (k < 6) check("rr_grant", 64'(req_ready), (k % 2 == 0) ? 64'(1) : 64'(2));
      if (k >= 2) begin
        int m;
        m = k - 2;
        chk_rsp("rr_rsp", 1'(m % 2), (m % 2 == 0) ? 4'(m) : 4'(8 + m),
                (m % 2 == 0) ? 32'(m + 100) : 32'(m + 200), 1'b0);
      end else begin
        check("rr_rsp_empty", 64'(rsp_valid), 64'(0));
      end
      tick();
    end
    settle();
    check("rr_drained", 64'(rsp_valid), 64'(0));

    // Back-pressure: only RSP_DEPTH grants while rsp_ready is low.
    rsp_ready = 1'b0;
    set_req(0, 32'h1000, 32'h1, AP_ADD, 4'd1);
    set_req(1, 32'h2000, 32'h2, AP_ADD, 4'd2);
    req_valid = 2'b11;
    settle();
    check("bp_c0_ready", 64'(req_ready), 64'(1));
    tick();
    settle();
    check("bp_c1_ready", 64'(req_ready), 64'(2));
    tick();
    settle();
    check("bp_c2_ready", 64'(req_ready), 64'(0));
    chk_rsp("bp_c2_head", 1'b0, 4'd1, 32'h1001, 1'b0);
    tick();
    settle();
    check("bp_c3_ready", 64'(req_ready), 64'(0));
    chk_rsp("bp_c3_hold", 1'b0, 4'd1, 32'h1001, 1'b0);
    tick();
    set_req(0, 32'h3000, 32'h3, AP_ADD, 4'd4);
    rsp_ready = 1'b1;
    settle();
    check("bp_pop_grant", 64'(req_ready), 64'(1));
    chk_rsp("bp_c4_head", 1'b0, 4'd1, 32'h1001, 1'b0);
    tick();
    rsp_ready = 1'b0;
    settle();
    check("bp_c5_ready", 64'(req_ready), 64'(0));
    chk_rsp("bp_c5_head", 1'b1, 4'd2, 32'h2002, 1'b0);
    tick();
    settle();
    check("bp_c6_ready", 64'(req_ready), 64'(0));
    chk_rsp("bp_c6_hold", 1'b1, 4'd2, 32'h2002, 1'b0);
    tick();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    settle();
    chk_rsp("bp_c7_head", 1'b1, 4'd2, 32'h2002, 1'b0);
    tick();
    settle();
    chk_rsp("bp_c8_head", 1'b0, 4'd4, 32'h3003, 1'b0);
    tick();
    settle();
    check("bp_drained", 64'(rsp_valid), 64'(0));

    // Error flag travels only with the tag-7 op.
    set_req(1, 32'h1, 32'h1, AP_ADD, 4'd6);
    req_valid = 2'b10;
    settle();
    check("err_d0_ready", 64'(req_ready), 64'(2));
    tick();
    set_req(0, 32'h2, 32'h2, AP_ERR, 4'd7);
    req_valid = 2'b01;
    settle();
    check("err_d1_ready", 64'(req_ready), 64'(1));
    tick();
    set_req(1, 32'h3, 32'h3, AP_ADD, 4'd8);
    req_valid = 2'b10;
    settle();
    check("err_d2_ready", 64'(req_ready), 64'(2));
    chk_rsp("err_rsp6", 1'b1, 4'd6, 32'h2, 1'b0);
    tick();
    req_valid = 2'b00;
    settle();
    chk_rsp("err_rsp7", 1'b0, 4'd7, 32'h4, 1'b1);
    tick();
    settle();
    chk_rsp("err_rsp8", 1'b1, 4'd8, 32'h6, 1'b0);
    tick();
    settle();
    check("err_drained", 64'(rsp_valid), 64'(0));

    // Flush with one queued and one in-flight result; pointer left at 1.
    rsp_ready = 1'b0;
    set_req(0, 32'h10, 32'h0, AP_ADD, 4'd1);
    req_valid = 2'b01;
    settle();
    check("fl_f0_ready", 64'(req_ready), 64'(1));
    tick();
    set_req(0, 32'h20, 32'h0, AP_ADD, 4'd2);
    settle();
    check("fl_f1_ready", 64'(req_ready), 64'(1));
    tick();
    rsp_ready = 1'b1;
    flush     = 1'b1;
    settle();
    check("fl_queued", 64'(rsp_valid), 64'(1));
    check("fl_no_grant", 64'(req_ready), 64'(0));
    check("fl_no_issue", 64'(bmu_valid_in), 64'(0));
    tick();
    flush     = 1'b0;
    rsp_ready = 1'b0;
    set_req(1, 32'h55, 32'h0, AP_ADD, 4'hA);
    req_valid = 2'b11;
    settle();
    check("fl_after_empty", 64'(rsp_valid), 64'(0));
    check("fl_ptr_kept", 64'(req_ready), 64'(2));
    tick();
    req_valid = 2'b00;
    settle();
    check("fl_inflight_dropped", 64'(rsp_valid), 64'(0));
    tick();
    settle();
    chk_rsp("fl_new_rsp", 1'b1, 4'hA, 32'h55, 1'b0);

    // Async reset with the FIFO holding an entry and the pointer at 1.
    set_req(0, 32'h66, 32'h0, AP_ADD, 4'hB);
    req_valid = 2'b01;
    settle();
    check("ar_pre_ready", 64'(req_ready), 64'(1));
    tick();
    set_req(0, 32'h77, 32'h1, AP_ADD, 4'hC);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    settle();
    check("ar_pre_rsp_valid", 64'(rsp_valid), 64'(1));
    check("ar_pre_grant1", 64'(req_ready), 64'(2));
    #1 rst_l = 1'b0;
    #1;
    check("ar_rsp_valid", 64'(rsp_valid), 64'(0));
    check("ar_req_ready", 64'(req_ready), 64'(0));
    check("ar_bmu_valid", 64'(bmu_valid_in), 64'(0));
    check("ar_rsp_tag", 64'(rsp_tag), 64'(0));
    #2 rst_l = 1'b1;
    #1;
    check("ar_first_grant0", 64'(req_ready), 64'(1));
    check("ar_post_empty", 64'(rsp_valid), 64'(0));
    tick();
    req_valid = 2'b00;
    settle();
    check("ar_lat1_empty", 64'(rsp_valid), 64'(0));
    tick();
    settle();
    chk_rsp("ar_post_rsp", 1'b0, 4'hC, 32'h78, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
